bus_sequencer: RTL and testbench
================================

# bus_sequencer

Clocked 68000 bus controller for the Pixy-68000 board, replacing the ad-hoc combinational/edge-triggered bus logic with a single-clock state machine. Decodes the 24-bit address into PROM, SRAM and I/O regions, handles the bootstrap PROM-over-SRAM overlay, and inserts per-region wait states before DTACK. It also raises BERR on unmapped accesses, supports a single-step (stepper) mode with a synchronised switch input, and provides a parametrised output/input signal port.

## Interface
- PROM_WAIT, default 2: wait cycles before DTACK for PROM accesses (0..15).
- SRAM_WAIT, default 0: wait cycles for SRAM accesses (0..15).
- IO_WAIT, default 0: wait cycles for the signal port (0..15).
- BERR_WAIT, default 32: cycles before BERR on an unmapped access (1..255).
- IN_WIDTH, default 4: input signal bits; IN_WIDTH+OUT_WIDTH ≤ 8.
- OUT_WIDTH, default 4: output signal bits.
- CPUCLK_IN  in  1  CPU clock; the only clock; all state on its rising edge.
- RESET_IN  in  1  asynchronous, active-high reset.
- STEPEN_IN  in  1  stepper mode enable (level, synchronised internally).
- STEP_IN  in  1  step push-switch (asynchronous, synchronised internally).
- AS_IN, WR_IN, UDS_IN, LDS_IN  in  1 each  active-high bus strobes; WR_IN=1 means write.
- ADDR_IN  in  24  byte address.
- INPUT_SIGNAL_IN  in  IN_WIDTH  external inputs (asynchronous).
- DATA  inout  16  CPU data bus.
- DTACK, BERR  out  1 each  registered acknowledge / bus error.
- PROMCS0, PROMCS1, SRAMCS0, SRAMCS1, OE  out  1 each  combinational chip selects (0 = even/UDS, 1 = odd/LDS).
- PAUSED  out  1  high while stepper holds a cycle.
- OUTPUT_SIGNAL  out  OUT_WIDTH  registered output port.

## Operation
- Regions: ADDR[23:20]=0x0 lower; 0x1 I/O; 0xF upper PROM. All other regions are unmapped. Within I/O, only the byte address 0x100001 accessed with LDS is the signal port; anything else is unmapped.
- Lower region:
  - PROM when ~BOOTSTRAPPED & ~WR_IN.
  - SRAM otherwise.
- BOOTSTRAPPED:
  - 0 on reset.
  - Set at the edge DTACK is asserted for a write to the lower region.
  - Never cleared except by reset.
- Chip selects:
  - PROMCS0 = AS&PROM&UDS; PROMCS1 = AS&PROM&LDS.
  - SRAMCS0 = AS&SRAM&UDS; SRAMCS1 = AS&SRAM&LDS.
  - OE = AS&(PROM|SRAM)&~WR_IN.
- DTREQ = AS_IN&(UDS_IN|LDS_IN).
- FSM states: IDLE, WAIT, HOLD, ACK, ERR.
  - IDLE: on DTREQ, latch region and direction. Load counter with the region wait, or BERR_WAIT if unmapped. Go to WAIT.
  - WAIT: counter decrements each cycle. At 0:
    - unmapped → assert BERR, go to ERR;
    - else if STEPEN synced → go to HOLD, PAUSED=1;
    - else → assert DTACK, go to ACK.
  - HOLD: on a synchronised rising edge of STEP_IN, assert DTACK, clear PAUSED, go to ACK.
  - ACK/ERR: hold DTACK/BERR until DTREQ samples low, then deassert on that edge and go to IDLE.
  - DTREQ dropping in WAIT/HOLD (aborted cycle) → IDLE with no acknowledge.
- Signal port write: at the DTACK-asserting edge, OUTPUT_SIGNAL ← DATA[IN_WIDTH+OUT_WIDTH-1:IN_WIDTH].
- Signal port read: DATA[7:0] = {zero pad, OUTPUT_SIGNAL, synced inputs} and DATA[15:8] = 0. Driven from the edge entering WAIT until the edge leaving ACK. DATA is high-Z at all other times.
- Synchronisers: STEP_IN, STEPEN_IN and INPUT_SIGNAL_IN each pass through 2 flops. The step edge detector uses the 2nd flop and a 3rd history flop.

## Timing
- Reset values:
  - state IDLE; DTACK=0, BERR=0, PAUSED=0; OUTPUT_SIGNAL=0; BOOTSTRAPPED=0.
  - Synchronisers 0; DATA released.
- Reset mid-cycle: immediate return to reset values; no DTACK is issued for the interrupted cycle.
- DTREQ first sampled at edge k: DTACK rises at edge k+1+W, where W is the region wait. SRAM_WAIT=0 gives DTACK at k+1.
- Unmapped access: BERR rises at edge k+1+BERR_WAIT.
- Stepper: HOLD entered at k+1+W. DTACK follows 3 edges after STEP_IN rises (2 sync edges plus the detect edge). Holding STEP_IN high does not re-trigger; a release is required before the next step.
- DTREQ low sampled at edge m in ACK: DTACK=0 at m and IDLE at m. A new DTREQ is accepted at m+1 at the earliest.
- STEPEN_IN changes take effect only at the WAIT→HOLD decision; a cycle already in HOLD stays there.

## Test plan
- Reset, then read word at 0x000000: PROMCS0/1=1, OE=1, DTACK at k+3 (PROM_WAIT=2). Write 0x1234 to 0x000010: SRAMCS0/1=1, DTACK at k+1. Re-read 0x000000: SRAMCS selected, BOOTSTRAPPED=1.
- Byte write 0x00A0 to 0x100001 with LDS only: OUTPUT_SIGNAL=4'hA. Byte read with INPUT_SIGNAL_IN=4'h5 held ≥2 cycles: DATA=16'h00A5. DATA is Z after AS negates.
- Read 0x800000: no chip select, no DTACK; BERR at k+33. BERR clears on the edge AS is sampled low.
- STEPEN_IN=1, SRAM read: PAUSED=1, DTACK stays 0 for 100 cycles. Pulse STEP_IN high for 10 cycles: exactly one DTACK, 3 edges after the rise. A second access then pauses again.
- Assert RESET_IN while in HOLD and while the I/O read is driving DATA: DTACK=0, PAUSED=0, DATA=Z, OUTPUT_SIGNAL=0, BOOTSTRAPPED=0 in the same cycle.
- AS negated during WAIT (PROM_WAIT=2, abort after 1 cycle): no DTACK. The next SRAM access acknowledges normally.

Source files
------------

// File: rtl/bus_sequencer.sv
// Clocked 68000 bus controller: address decode, bootstrap PROM overlay, per-region
// wait states, bus error on unmapped cycles, single-step hold and a small signal port.
module bus_sequencer #(
    parameter int PROM_WAIT = 2,
    parameter int SRAM_WAIT = 0,
    parameter int IO_WAIT   = 0,
    parameter int BERR_WAIT = 32,
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4
) (
    input  logic                 CPUCLK_IN,
    input  logic                 RESET_IN,
    input  logic                 STEPEN_IN,
    input  logic                 STEP_IN,
    input  logic                 AS_IN,
    input  logic                 WR_IN,
    input  logic                 UDS_IN,
    input  logic                 LDS_IN,
    input  logic [23:0]          ADDR_IN,
    input  logic [IN_WIDTH-1:0]  INPUT_SIGNAL_IN,
    inout  wire  [15:0]          DATA,
    output logic                 DTACK,
    output logic                 BERR,
    output logic                 PROMCS0,
    output logic                 PROMCS1,
    output logic                 SRAMCS0,
    output logic                 SRAMCS1,
    output logic                 OE,
    output logic                 PAUSED,
    output logic [OUT_WIDTH-1:0] OUTPUT_SIGNAL
);
    localparam int DW = IN_WIDTH + OUT_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_ACK, S_ERR} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_q, err_d, sig_q, sig_d, wr_q, wr_d, low_q, low_d;
    logic                 dtack_q, dtack_d, berr_q, berr_d, paused_q, paused_d;
    logic                 drive_q, drive_d, boot_q, boot_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [1:0]           stepen_q;
    logic [2:0]           step_q;
    logic [IN_WIDTH-1:0]  in1_q, in2_q;

    logic dtreq, lower, upper, sig, prom, sram, unmapped, step_rise, ack;
    logic [7:0] load_cnt, port_rd;
    logic data_unused;

    assign dtreq    = AS_IN & (UDS_IN | LDS_IN);
    assign lower    = (ADDR_IN[23:20] == 4'h0);
    assign upper    = (ADDR_IN[23:20] == 4'hF);
    assign sig      = (ADDR_IN == 24'h100001) & LDS_IN;
    // Until the first write into the lower region, reads there see the boot PROM.
    assign prom     = upper | (lower & ~boot_q & ~WR_IN);
    assign sram     = lower & (boot_q | WR_IN);
    assign unmapped = ~(lower | upper | sig);

    assign PROMCS0 = AS_IN & prom & UDS_IN;
    assign PROMCS1 = AS_IN & prom & LDS_IN;
    assign SRAMCS0 = AS_IN & sram & UDS_IN;
    assign SRAMCS1 = AS_IN & sram & LDS_IN;
    assign OE      = AS_IN & (prom | sram) & ~WR_IN;

    assign load_cnt  = unmapped ? 8'(BERR_WAIT) : prom ? 8'(PROM_WAIT) :
                       sram ? 8'(SRAM_WAIT) : 8'(IO_WAIT);
    assign step_rise = step_q[1] & ~step_q[2];

    assign port_rd     = 8'({out_q, in2_q});
    assign DATA        = drive_q ? {8'h00, port_rd} : 16'hzzzz;
    assign data_unused = ^DATA;

    assign DTACK         = dtack_q;
    assign BERR          = berr_q;
    assign PAUSED        = paused_q;
    assign OUTPUT_SIGNAL = out_q;

    always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            stepen_q <= '0;
            step_q   <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
        end else begin
            stepen_q <= {stepen_q[0], STEPEN_IN};
            step_q   <= {step_q[1:0], STEP_IN};
            in1_q    <= INPUT_SIGNAL_IN;
            in2_q    <= in1_q;
        end
    end

    always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            sig_q    <= 1'b0;
            wr_q     <= 1'b0;
            low_q    <= 1'b0;
            dtack_q  <= 1'b0;
            berr_q   <= 1'b0;
            paused_q <= 1'b0;
            drive_q  <= 1'b0;
            boot_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sig_q    <= sig_d;
            wr_q     <= wr_d;
            low_q    <= low_d;
            dtack_q  <= dtack_d;
            berr_q   <= berr_d;
            paused_q <= paused_d;
            drive_q  <= drive_d;
            boot_q   <= boot_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sig_d    = sig_q;
        wr_d     = wr_q;
        low_d    = low_q;
        dtack_d  = dtack_q;
        berr_d   = berr_q;
        paused_d = paused_q;
        drive_d  = drive_q;
        boot_d   = boot_q;
        out_d    = out_q;
        ack      = 1'b0;
        case (state_q)
            S_IDLE: if (dtreq) begin
                err_d   = unmapped;
                sig_d   = sig;
                wr_d    = WR_IN;
                low_d   = lower;
                cnt_d   = load_cnt;
                drive_d = sig & ~WR_IN;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!dtreq) begin
                    drive_d = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (err_q) begin
                    berr_d  = 1'b1;
                    state_d = S_ERR;
                end else if (stepen_q[1]) begin
                    paused_d = 1'b1;
                    state_d  = S_HOLD;
                end else begin
                    ack = 1'b1;
                end
            end
            S_HOLD: begin
                if (!dtreq) begin
                    paused_d = 1'b0;
                    drive_d  = 1'b0;
                    state_d  = S_IDLE;
                end else if (step_rise) begin
                    paused_d = 1'b0;
                    ack      = 1'b1;
                end
            end
            S_ACK: if (!dtreq) begin
                dtack_d = 1'b0;
                drive_d = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: if (!dtreq) begin
                berr_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Side effects of a completed cycle happen on the edge DTACK rises.
        if (ack) begin
            dtack_d = 1'b1;
            state_d = S_ACK;
            if (wr_q && low_q) boot_d = 1'b1;
            if (wr_q && sig_q) out_d = DATA[DW-1:IN_WIDTH];
        end
    end
endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: stimulus pushes expected acknowledges into a
// scoreboard; a monitor pops and checks kind, edge and read data on each DTACK/BERR rise.
module tb_bus_sequencer;
    logic        clk = 1'b0, rst = 1'b0, stepen = 1'b0, step = 1'b0;
    logic        as_n = 1'b0, wr = 1'b0, uds = 1'b0, lds = 1'b0;
    logic [23:0] addr = '0;
    logic [3:0]  insig = '0;
    logic        tb_en = 1'b0;
    logic [15:0] tb_val = '0;
    wire  [15:0] data;
    logic        dtack, berr, pcs0, pcs1, scs0, scs1, oe, paused;
    logic [3:0]  outsig;

    assign data = tb_en ? tb_val : 16'hzzzz;

    bus_sequencer dut (
        .CPUCLK_IN(clk), .RESET_IN(rst), .STEPEN_IN(stepen), .STEP_IN(step),
        .AS_IN(as_n), .WR_IN(wr), .UDS_IN(uds), .LDS_IN(lds), .ADDR_IN(addr),
        .INPUT_SIGNAL_IN(insig), .DATA(data), .DTACK(dtack), .BERR(berr),
        .PROMCS0(pcs0), .PROMCS1(pcs1), .SRAMCS0(scs0), .SRAMCS1(scs1), .OE(oe),
        .PAUSED(paused), .OUTPUT_SIGNAL(outsig)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    typedef struct {
        bit          is_berr;
        int          edge_n;
        logic [15:0] rd;
        bit          chkd;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    logic pd = 1'b0, pb = 1'b0;
    always @(posedge clk) begin
        #1;
        if ((dtack && !pd) || (berr && !pb)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: dtack=%0b berr=%0b at edge %0d, required none",
                         dtack, berr, cyc);
            end else begin
                e = sb.pop_front();
                chk("ack_kind", {31'd0, berr}, {31'd0, e.is_berr});
                chk("ack_edge", cyc, e.edge_n);
                if (e.chkd) chk("read_data", {16'd0, data}, {16'd0, e.rd});
            end
        end
        pd = dtack;
        pb = berr;
    end

    task automatic start(input logic [23:0] a, input logic w, input logic u, input logic l,
                         input logic [15:0] wd, output int k);
        @(negedge clk);
        addr = a; wr = w; uds = u; lds = l; as_n = 1'b1;
        tb_en = w; tb_val = wd;
        k = cyc + 1;
    endtask

    task automatic finish_cycle(input int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dtack || berr) && n < maxc);
        chk("ack_timeout", {31'd0, dtack | berr}, 32'd1);
        as_n = 1'b0; uds = 1'b0; lds = 1'b0; tb_en = 1'b0;
        @(negedge clk);
        chk("ack_release", {30'd0, dtack, berr}, 32'd0);
    endtask

    task automatic wait_paused(input int maxc);
        int n = 0;
        while (!paused && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", {31'd0, paused}, 32'd1);
    endtask

    task automatic probe_release(input string name);
        tb_en = 1'b1; tb_val = 16'h0000;
        #1 chk(name, {16'd0, data}, 32'd0);
        tb_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, t0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dtack", {31'd0, dtack}, 32'd0);
        chk("rst_berr", {31'd0, berr}, 32'd0);
        chk("rst_paused", {31'd0, paused}, 32'd0);
        chk("rst_outsig", {28'd0, outsig}, 32'd0);
        probe_release("rst_data_z");
        rst = 1'b0;
        insig = 4'h5;
        @(negedge clk);

        // Boot PROM read, SRAM write, then SRAM overlays the lower region.
        start(24'h000000, 1'b0, 1'b1, 1'b1, 16'h0, k);
        sb.push_back('{1'b0, k + 3, 16'h0, 1'b0});
        #1 chk("prom_cs", {29'd0, pcs0, pcs1, oe}, 32'h7);
        chk("prom_no_sram", {30'd0, scs0, scs1}, 32'd0);
        finish_cycle(10);

        start(24'h000010, 1'b1, 1'b1, 1'b1, 16'h1234, k);
        sb.push_back('{1'b0, k + 1, 16'h0, 1'b0});
        #1 chk("sram_wr_cs", {27'd0, scs0, scs1, pcs0, pcs1, oe}, 32'h18);
        finish_cycle(10);

        start(24'h000000, 1'b0, 1'b1, 1'b1, 16'h0, k);
        sb.push_back('{1'b0, k + 1, 16'h0, 1'b0});
        #1 chk("boot_sram_cs", {27'd0, scs0, scs1, pcs0, pcs1, oe}, 32'h19);
        finish_cycle(10);

        // Signal port write then read.
        start(24'h100001, 1'b1, 1'b0, 1'b1, 16'h00A0, k);
        sb.push_back('{1'b0, k + 1, 16'h0, 1'b0});
        #1 chk("io_no_cs", {27'd0, pcs0, pcs1, scs0, scs1, oe}, 32'd0);
        finish_cycle(10);
        chk("outsig_wr", {28'd0, outsig}, 32'hA);

        start(24'h100001, 1'b0, 1'b0, 1'b1, 16'h0, k);
        sb.push_back('{1'b0, k + 1, 16'h00A5, 1'b1});
        finish_cycle(10);
        probe_release("io_data_z");

        // Unmapped access raises BERR.
        start(24'h800000, 1'b0, 1'b1, 1'b1, 16'h0, k);
        sb.push_back('{1'b1, k + 33, 16'h0, 1'b0});
        #1 chk("unmapped_no_cs", {27'd0, pcs0, pcs1, scs0, scs1, oe}, 32'd0);
        finish_cycle(60);

        // Stepper: hold, one step per release/press.
        stepen = 1'b1;
        repeat (3) @(negedge clk);
        start(24'h000010, 1'b0, 1'b1, 1'b1, 16'h0, k);
        repeat (100) @(negedge clk);
        chk("step_paused", {31'd0, paused}, 32'd1);
        chk("step_no_ack", {31'd0, dtack}, 32'd0);
        step = 1'b1;
        t0 = cyc;
        sb.push_back('{1'b0, cyc + 3, 16'h0, 1'b0});
        finish_cycle(10);
        start(24'h000010, 1'b0, 1'b1, 1'b1, 16'h0, k);
        while (cyc < t0 + 10) @(negedge clk);
        step = 1'b0;
        repeat (20) @(negedge clk);
        chk("step_held_paused", {31'd0, paused}, 32'd1);
        chk("step_held_no_ack", {31'd0, dtack}, 32'd0);
        step = 1'b1;
        sb.push_back('{1'b0, cyc + 3, 16'h0, 1'b0});
        finish_cycle(10);
        step = 1'b0;

        // Reset while holding an I/O read that drives DATA.
        start(24'h100001, 1'b0, 1'b0, 1'b1, 16'h0, k);
        wait_paused(20);
        chk("hold_data", {16'd0, data}, 32'h00A5);
        rst = 1'b1;
        #1 chk("mid_rst_paused", {31'd0, paused}, 32'd0);
        chk("mid_rst_dtack", {31'd0, dtack}, 32'd0);
        chk("mid_rst_outsig", {28'd0, outsig}, 32'd0);
        probe_release("mid_rst_data_z");
        as_n = 1'b0; uds = 1'b0; lds = 1'b0; stepen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Overlay is back after reset.
        start(24'h000000, 1'b0, 1'b1, 1'b1, 16'h0, k);
        sb.push_back('{1'b0, k + 3, 16'h0, 1'b0});
        #1 chk("reboot_prom_cs", {28'd0, pcs0, pcs1, scs0, scs1}, 32'hC);
        finish_cycle(10);

        // Aborted PROM cycle, then a normal SRAM write.
        start(24'h000000, 1'b0, 1'b1, 1'b1, 16'h0, k);
        @(negedge clk);
        as_n = 1'b0; uds = 1'b0; lds = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_ack", {31'd0, dtack}, 32'd0);
        start(24'h000010, 1'b1, 1'b1, 1'b1, 16'h5678, k);
        sb.push_back('{1'b0, k + 1, 16'h0, 1'b0});
        finish_cycle(10);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
